// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronize, glitch-filter, track Gray code, emit per-detent cw/ccw pulses.
// Pulse latency is SYNC_STAGES+FILTER_CYCLES+1 edges from the sampling edge; no backpressure (pulses are fire-and-forget).
module quad_decoder #(
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_CYCLES     = 4,
  parameter int COUNTS_PER_DETENT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  input  logic b,
  output logic cw,
  output logic ccw,
  output logic err
);

  localparam int SW = $clog2(COUNTS_PER_DETENT) + 2;
  localparam int IW = 9;
  localparam logic [IW-1:0]        INIT_LAST = IW'(SYNC_STAGES + FILTER_CYCLES);
  localparam logic [7:0]           FILT_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic signed [SW-1:0] CPOS      = SW'(COUNTS_PER_DETENT);
  localparam logic signed [SW-1:0] CNEG      = -CPOS;
  localparam logic signed [SW-1:0] ONE       = SW'(1);
  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [SYNC_STAGES-1:0]  sync_a;
  logic [SYNC_STAGES-1:0]  sync_b;
  logic [1:0]              s;
  logic [1:0]              f;
  logic [7:0]              fcnt [2];
  logic [0:0]              state;
  logic [IW-1:0]           init_cnt;
  logic [1:0]              prev;
  logic signed [SW-1:0]    sub;
  logic signed [SW-1:0]    sub_base;
  logic signed [SW-1:0]    sub_nxt;
  logic [1:0]              dpos;
  logic                    step_up;
  logic                    step_dn;
  logic                    illegal;
  logic                    err_pend;

  // Position along the cw sequence 00->10->11->01; a difference of 1 is cw, 3 is ccw, 2 is illegal.
  function automatic logic [1:0] gpos(input logic [1:0] v);
    return {v[0], v[1] ^ v[0]};
  endfunction

  assign s = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f <= '0;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] != f[i]) begin
          if (fcnt[i] == FILT_LAST) begin
            f[i]    <= s[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 8'd1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    dpos     = gpos(f) - gpos(prev);
    step_up  = (state == TRACK) && (dpos == 2'd1);
    step_dn  = (state == TRACK) && (dpos == 2'd3);
    illegal  = (state == TRACK) && (dpos == 2'd2);
    // A completed detent is cleared on the same cycle its pulse is issued.
    sub_base = ((sub == CPOS) || (sub == CNEG)) ? '0 : sub;
    sub_nxt  = sub_base;
    if (illegal)      sub_nxt = '0;
    else if (step_up) sub_nxt = sub_base + ONE;
    else if (step_dn) sub_nxt = sub_base - ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      init_cnt <= '0;
      prev     <= '0;
      sub      <= '0;
      err_pend <= 1'b0;
      cw       <= 1'b0;
      ccw      <= 1'b0;
      err      <= 1'b0;
    end else begin
      sub      <= sub_nxt;
      err_pend <= illegal;
      cw       <= (sub == CPOS);
      ccw      <= (sub == CNEG);
      err      <= err_pend;
      if (state == INIT) begin
        if (init_cnt == INIT_LAST) begin
          prev  <= f;
          state <= TRACK;
        end else begin
          init_cnt <= init_cnt + 1'b1;
        end
      end else begin
        prev <= f;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized bench for quad_decoder: raw-level run-length model predicts filtered edges, steps and pulse timing.
module tb_quad_decoder;

  localparam int S   = 2;
  localparam int F   = 4;
  localparam int C   = 4;
  localparam int LAT = S + F + 1;

  logic clk = 1'b0;
  logic reset_n;
  logic a;
  logic b;
  logic cw;
  logic ccw;
  logic err;

  always #5 clk = ~clk;

  quad_decoder #(.SYNC_STAGES(S), .FILTER_CYCLES(F), .COUNTS_PER_DETENT(C)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .cw(cw), .ccw(ccw), .err(err)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int         e;
  logic [1:0] run_val;
  int         run_len [2];
  logic [1:0] facc;
  logic [1:0] fm;
  int         sub;
  logic [2:0] exp_ev [256];
  logic [1:0] chg [256];
  int         ring [4] = '{0, 2, 3, 1};
  int         exp_pulses;

  // Observed
  int n_cw, n_ccw, n_er, obs_pulses;
  int last_cw_edge, last_err_edge;

  function automatic logic [1:0] nxt(input logic [1:0] v, input bit dir_cw);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (ring[i] == int'(v)) idx = i;
    return 2'(ring[dir_cw ? (idx + 1) % 4 : (idx + 3) % 4]);
  endfunction

  task automatic model_clear();
    e = 0; run_val = 2'b00; run_len[0] = 0; run_len[1] = 0;
    facc = 2'b00; fm = 2'b00; sub = 0;
    for (int i = 0; i < 256; i++) begin exp_ev[i] = 3'b000; chg[i] = 2'b00; end
    n_cw = 0; n_ccw = 0; n_er = 0;
  endtask

  // A raw run of F or more cycles at a new level reaches the filtered level S+F-1 edges after its first sample.
  task automatic model_edge(input logic [1:0] ab, output logic [2:0] ex);
    logic [1:0] mask;
    logic [1:0] cur;
    for (int ch = 0; ch < 2; ch++) begin
      if (ab[ch] == run_val[ch]) run_len[ch]++;
      else begin run_val[ch] = ab[ch]; run_len[ch] = 1; end
      if (run_len[ch] == F && ab[ch] != facc[ch]) begin
        facc[ch] = ab[ch];
        chg[(e + S) % 256][ch] = 1'b1;
      end
    end
    mask = chg[e % 256];
    chg[e % 256] = 2'b00;
    if (mask != 2'b00) begin
      if (e >= S + F + 1) begin
        if (mask == 2'b11) begin
          exp_ev[(e + 2) % 256] = 3'b001; sub = 0; exp_pulses++;
        end else begin
          cur = fm ^ mask;
          if (cur == nxt(fm, 1'b1)) sub++; else sub--;
          if (sub == C)       begin exp_ev[(e + 2) % 256] = 3'b100; sub = 0; exp_pulses++; end
          else if (sub == -C) begin exp_ev[(e + 2) % 256] = 3'b010; sub = 0; exp_pulses++; end
        end
      end
      fm = fm ^ mask;
    end
    ex = exp_ev[e % 256];
    exp_ev[e % 256] = 3'b000;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input logic [1:0] ab);
    logic [2:0] ex;
    a = ab[1]; b = ab[0];
    @(posedge clk);
    e++;
    model_edge(ab, ex);
    #1;
    chk("outputs", {cw, ccw, err}, ex);
    if (cw === 1'b1)  begin n_cw++;  last_cw_edge = e;  obs_pulses++; end
    if (ccw === 1'b1) begin n_ccw++; obs_pulses++; end
    if (err === 1'b1) begin n_er++;  last_err_edge = e; obs_pulses++; end
    @(negedge clk);
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) tick(ab);
  endtask

  task automatic do_reset(input logic [1:0] ab, input int n);
    a = ab[1]; b = ab[0];
    reset_n = 1'b0;
    #1;
    chk("reset_async", {cw, ccw, err}, 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", {cw, ccw, err}, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic detent(input logic [1:0] start, input bit dir_cw);
    logic [1:0] v = start;
    for (int i = 0; i < 4; i++) begin
      v = nxt(v, dir_cw);
      hold(v, $urandom_range(10, 14));
    end
  endtask

  initial begin
    int t0;
    logic [1:0] cur;
    logic [1:0] gm;
    reset_n = 1'b0; a = 1'b0; b = 1'b0;
    exp_pulses = 0; obs_pulses = 0; last_cw_edge = 0; last_err_edge = 0;
    model_clear();
    @(negedge clk);

    // Idle at 11 through reset, then prove 11 was captured as the reference
    do_reset(2'b11, 3);
    hold(2'b11, 20);
    chk("idle_pulses", n_cw + n_ccw + n_er, 0);
    detent(2'b11, 1'b1);
    chk("idle_then_cw", n_cw, 1);
    chk("idle_then_err", n_er, 0);

    // One clockwise detent with latency check
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
    t0 = e + 1;
    hold(2'b00, 12);
    chk("cw_count", n_cw, 1);
    chk("cw_no_ccw", n_ccw + n_er, 0);
    chk("cw_latency", last_cw_edge - t0, LAT);

    // Two counter-clockwise detents
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    detent(2'b00, 1'b0);
    detent(2'b00, 1'b0);
    chk("ccw_count", n_ccw, 2);
    chk("ccw_no_cw", n_cw + n_er, 0);

    // Glitch rejection, then an accepted 5-cycle level completes a later detent
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    for (int i = 0; i < 5; i++) begin
      hold(2'b10, 3);
      hold(2'b00, $urandom_range(3, 8));
    end
    chk("glitch_none", n_cw + n_ccw + n_er, 0);
    hold(2'b10, 5);
    hold(2'b10, 10);
    chk("glitch_step_no_pulse", n_cw + n_ccw + n_er, 0);
    hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 12);
    chk("glitch_then_cw", n_cw, 1);

    // Reversal mid-detent, then illegal jump, then a clean detent
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 12);
    chk("reversal_none", n_cw + n_ccw + n_er, 0);
    t0 = e + 1;
    hold(2'b11, 12);
    chk("jump_err", n_er, 1);
    chk("jump_err_latency", last_err_edge - t0, LAT);
    detent(2'b11, 1'b1);
    chk("jump_then_cw", n_cw, 1);
    chk("jump_no_ccw", n_ccw, 0);

    // Reset mid-detent discards the partial count
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
    do_reset(2'b01, 2);
    hold(2'b01, 12);
    hold(2'b00, 12);
    chk("midreset_none", n_cw + n_ccw + n_er, 0);
    detent(2'b00, 1'b1);
    chk("midreset_then_cw", n_cw, 1);

    // Random walk with glitches and occasional illegal jumps
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    exp_pulses = 0; obs_pulses = 0;
    cur = 2'b00;
    for (int k = 0; k < 200; k++) begin
      int r = $urandom_range(0, 19);
      if (r < 8)       cur = nxt(cur, 1'b1);
      else if (r < 16) cur = nxt(cur, 1'b0);
      else if (r < 18) begin
        gm = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
        hold(cur ^ gm, $urandom_range(1, F - 1));
      end else if (r == 18) cur = cur ^ 2'b11;
      hold(cur, $urandom_range(F, F + 6));
    end
    hold(cur, 12);
    chk("rand_pulses", obs_pulses, exp_pulses);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
